hilo_unit: RTL and testbench

//  HI/LO register unit directly downstream of the ALU in the multi-cycle CPU.
//  On a MULT/MULTU/DIV/DIVU start it waits a fixed number of cycles for the
//  ALU's deep combinational mul/div result to settle, then captures the 64-bit

---
 rtl/hilo_pkg.sv | 39 +++
 rtl/hilo_settle_ctr.sv | 32 +++
 rtl/hilo_unit.sv | 143 ++++++++++++++
 tb/tb_hilo_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// hilo_pkg : ALU opcodes, HI/LO FSM state encoding and counter sizing helper.
// Revision : 1.0
//------------------------------------------------------------------------------
package hilo_pkg;

   localparam logic [4:0] ALUOP_ADD   = 5'h00;
   localparam logic [4:0] ALUOP_SUB   = 5'h01;
   localparam logic [4:0] ALUOP_AND   = 5'h02;
   localparam logic [4:0] ALUOP_OR    = 5'h03;
   localparam logic [4:0] ALUOP_MULT  = 5'h18;
   localparam logic [4:0] ALUOP_MULTU = 5'h19;
   localparam logic [4:0] ALUOP_DIV   = 5'h1A;
   localparam logic [4:0] ALUOP_DIVU  = 5'h1B;

   typedef enum logic [1:0] {
      HILO_IDLE   = 2'd0,
      HILO_SETTLE = 2'd1,
      HILO_DONE   = 2'd2
   } hilo_state_e;

   // Wide enough to hold the larger (LAT-1) load value; never narrower than 1.
   function automatic int hilo_ctr_width(input int mul_lat, input int div_lat);
      int m;
      m = (mul_lat > div_lat) ? mul_lat : div_lat;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == ALUOP_MULT) || (op == ALUOP_MULTU) || is_div(op);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_settle_ctr.sv
`default_nettype none
//------------------------------------------------------------------------------
// hilo_settle_ctr : loadable down-counter with zero flag.
// Revision : 1.0
//------------------------------------------------------------------------------
module hilo_settle_ctr #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// hilo_unit : HI/LO register unit; waits for mul/div result to settle, then
//             captures it. Optional macro HILO_DIV0_GUARD_EN skips divide-by-zero.
// Revision : 1.0
//------------------------------------------------------------------------------
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [4:0]  aluop_i,
   input  logic [63:0] aluout_i,
   input  logic        div0_i,
   input  logic        mthi_i,
   input  logic        mtlo_i,
   input  logic [31:0] wdata_i,
   input  logic        rd_hi_i,
   output logic [31:0] rdata_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        div0_o
);

   localparam int            CW       = hilo_ctr_width(MUL_LAT, DIV_LAT);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

   hilo_state_e   state;
   hilo_state_e   state_nxt;
   logic [31:0]   hi;
   logic [31:0]   lo;
   logic          start_ok;
   logic          div0_skip;
   logic          ctr_load;
   logic          ctr_dec;
   logic          ctr_zero;
   logic          capture;
   logic          mt_ok;
   logic [CW-1:0] ctr_load_val;

   assign start_ok = start_i && is_muldiv(aluop_i) && (state != HILO_SETTLE);

`ifdef HILO_DIV0_GUARD_EN
   logic div0_flag;

   assign div0_skip = start_ok && is_div(aluop_i) && div0_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div0_flag <= 1'b0;
      end else if (div0_skip) begin
         div0_flag <= 1'b1;
      end
   end

   assign div0_o = div0_flag;
`else
   logic unused_div0;

   assign unused_div0 = div0_i;
   assign div0_skip   = 1'b0;
   assign div0_o      = 1'b0;
`endif

   assign ctr_load     = start_ok && !div0_skip;
   assign ctr_load_val = is_div(aluop_i) ? DIV_LOAD : MUL_LOAD;
   assign ctr_dec      = (state == HILO_SETTLE) && !ctr_zero;
   assign capture      = (state == HILO_SETTLE) && ctr_zero;
   // An accepted start takes priority over a same-cycle MTHI/MTLO.
   assign mt_ok        = (state != HILO_SETTLE) && !start_ok;

   hilo_settle_ctr #(
      .WIDTH (CW)
   ) u_settle_ctr (
      .clk      (clk_i),
      .rst_n    (rst_n_i),
      .load     (ctr_load),
      .load_val (ctr_load_val),
      .dec      (ctr_dec),
      .zero     (ctr_zero)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= HILO_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         HILO_IDLE, HILO_DONE: begin
            done_o = (state == HILO_DONE);
            if (start_ok) begin
               state_nxt = div0_skip ? HILO_DONE : HILO_SETTLE;
            end else begin
               state_nxt = HILO_IDLE;
            end
         end
         HILO_SETTLE: begin
            busy_o = 1'b1;
            if (ctr_zero) begin
               state_nxt = HILO_DONE;
            end
         end
         default: state_nxt = HILO_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hi <= '0;
         lo <= '0;
      end else if (capture) begin
         hi <= aluout_i[63:32];
         lo <= aluout_i[31:0];
      end else if (mt_ok) begin
         if (mthi_i) begin
            hi <= wdata_i;
         end
         if (mtlo_i) begin
            lo <= wdata_i;
         end
      end
   end

   assign hi_o    = hi;
   assign lo_o    = lo;
   assign rdata_o = rd_hi_i ? hi : lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_hilo_unit : directed + randomized self-checking bench for hilo_unit.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_hilo_unit;
   import hilo_pkg::*;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 4;

   logic        clk      = 1'b0;
   logic        rst_n_i  = 1'b0;
   logic        start_i  = 1'b0;
   logic [4:0]  aluop_i  = ALUOP_ADD;
   logic [63:0] aluout_i = '0;
   logic        div0_i   = 1'b0;
   logic        mthi_i   = 1'b0;
   logic        mtlo_i   = 1'b0;
   logic [31:0] wdata_i  = '0;
   logic        rd_hi_i  = 1'b0;
   logic [31:0] rdata_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        busy_o;
   logic        done_o;
   logic        div0_o;

   hilo_unit #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n_i),
      .start_i  (start_i),
      .aluop_i  (aluop_i),
      .aluout_i (aluout_i),
      .div0_i   (div0_i),
      .mthi_i   (mthi_i),
      .mtlo_i   (mtlo_i),
      .wdata_i  (wdata_i),
      .rd_hi_i  (rd_hi_i),
      .rdata_o  (rdata_o),
      .hi_o     (hi_o),
      .lo_o     (lo_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .div0_o   (div0_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: remaining busy cycles plus the architectural HI/LO.
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;
   int          m_busy = 0;
   bit          m_done = 1'b0;
   bit          m_div0 = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 1'b0; m_div0 = 1'b0;
   endtask

   task automatic model_edge();
      bit md, dv;
      md = (aluop_i == ALUOP_MULT) || (aluop_i == ALUOP_MULTU) ||
           (aluop_i == ALUOP_DIV)  || (aluop_i == ALUOP_DIVU);
      dv = (aluop_i == ALUOP_DIV)  || (aluop_i == ALUOP_DIVU);
      if (m_busy > 0) begin
         m_busy--;
         m_done = (m_busy == 0);
         if (m_busy == 0) begin
            m_hi = aluout_i[63:32];
            m_lo = aluout_i[31:0];
         end
      end else begin
         m_done = 1'b0;
         if (start_i && md) begin
`ifdef HILO_DIV0_GUARD_EN
            if (dv && div0_i) begin
               m_done = 1'b1;
               m_div0 = 1'b1;
            end else begin
               m_busy = dv ? DIV_LAT : MUL_LAT;
            end
`else
            m_busy = dv ? DIV_LAT : MUL_LAT;
`endif
         end else begin
            if (mthi_i) m_hi = wdata_i;
            if (mtlo_i) m_lo = wdata_i;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".hi"},    64'(hi_o),    64'(m_hi));
      chk({tag, ".lo"},    64'(lo_o),    64'(m_lo));
      chk({tag, ".busy"},  64'(busy_o),  64'(m_busy > 0));
      chk({tag, ".done"},  64'(done_o),  64'(m_done));
      chk({tag, ".rdata"}, 64'(rdata_o), 64'(rd_hi_i ? m_hi : m_lo));
      chk({tag, ".div0"},  64'(div0_o),  64'(m_div0));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic clear_inputs();
      start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; div0_i = 1'b0; aluop_i = ALUOP_ADD;
   endtask

   initial begin
      logic [4:0] op;
      int         r;

      // Reset state
      #12;
      chk("reset.hi", 64'(hi_o), 64'h0);
      chk("reset.lo", 64'(lo_o), 64'h0);
      chk("reset.busy", 64'(busy_o), 64'h0);
      chk("reset.done", 64'(done_o), 64'h0);
      rst_n_i = 1'b1;
      tick("idle");

      // MULT: busy for MUL_LAT cycles then done
      aluop_i = ALUOP_MULT; aluout_i = 64'hFFFF_FFFF_FFFF_FFFA; start_i = 1'b1;
      tick("mult.c1");
      chk("mult.busy1", 64'(busy_o), 64'h1);
      clear_inputs();
      tick("mult.c2");
      chk("mult.busy2", 64'(busy_o), 64'h1);
      tick("mult.c3");
      chk("mult.done", 64'(done_o), 64'h1);
      chk("mult.hi", 64'(hi_o), 64'hFFFF_FFFF);
      chk("mult.lo", 64'(lo_o), 64'hFFFF_FFFA);
      tick("mult.idle");

      // DIVU with MTLO noise and ignored starts during SETTLE
      aluop_i = ALUOP_DIVU; aluout_i = {32'd1, 32'd3}; start_i = 1'b1;
      tick("divu.c1");
      clear_inputs();
      mtlo_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
      tick("divu.mtlo");
      mtlo_i = 1'b0; start_i = 1'b1; aluop_i = ALUOP_MULT;
      tick("divu.start_in_settle");
      clear_inputs();
      tick("divu.c4");
      chk("divu.lo_kept", 64'(lo_o), 64'hFFFF_FFFA);
      // b2b: start MULTU in the DONE cycle
      aluop_i = ALUOP_MULTU; start_i = 1'b1;
      tick("divu.done");
      chk("divu.hi", 64'(hi_o), 64'h1);
      chk("divu.lo", 64'(lo_o), 64'h3);
      chk("divu.done_pulse", 64'(done_o), 64'h1);
      aluout_i = 64'h0000_0002_0000_0004;
      tick("b2b.c1");
      chk("b2b.busy", 64'(busy_o), 64'h1);
      clear_inputs();
      tick("b2b.c2");
      tick("b2b.done");
      tick("b2b.idle");

      // start with non-mul/div op is ignored
      start_i = 1'b1; aluop_i = ALUOP_ADD;
      tick("add.ignored");
      chk("add.busy", 64'(busy_o), 64'h0);
      clear_inputs();

      // MTHI then MTLO, then both at once
      mthi_i = 1'b1; wdata_i = 32'h1234;
      tick("mthi");
      mthi_i = 1'b0; mtlo_i = 1'b1; wdata_i = 32'h5678;
      tick("mtlo");
      mtlo_i = 1'b0;
      rd_hi_i = 1'b1; #1;
      chk("rd.hi", 64'(rdata_o), 64'h1234);
      rd_hi_i = 1'b0; #1;
      chk("rd.lo", 64'(rdata_o), 64'h5678);
      mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hA5A5_0F0F;
      tick("mt.both");
      clear_inputs();

      // DIV with div0 flag
      aluop_i = ALUOP_DIV; aluout_i = 64'h1111_2222_3333_4444; div0_i = 1'b1; start_i = 1'b1;
      tick("div0.c1");
      clear_inputs();
      for (int i = 0; i < DIV_LAT + 1; i++) tick("div0.run");

      // Asynchronous reset mid-SETTLE
      aluop_i = ALUOP_DIV; aluout_i = 64'h7777_8888_9999_AAAA; start_i = 1'b1;
      tick("rst.start");
      clear_inputs();
      rst_n_i = 1'b0;
      #1;
      model_reset();
      chk("rst.hi", 64'(hi_o), 64'h0);
      chk("rst.lo", 64'(lo_o), 64'h0);
      chk("rst.busy", 64'(busy_o), 64'h0);
      chk("rst.done", 64'(done_o), 64'h0);
      #1;
      rst_n_i = 1'b1;
      tick("rst.after");

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         clear_inputs();
         r = $urandom_range(0, 9);
         if (r < 4) begin
            case ($urandom_range(0, 4))
               0:       op = ALUOP_MULT;
               1:       op = ALUOP_MULTU;
               2:       op = ALUOP_DIV;
               3:       op = ALUOP_DIVU;
               default: op = ALUOP_SUB;
            endcase
            aluop_i = op;
            start_i = 1'b1;
         end else if (r < 8) begin
            mthi_i = 1'($urandom_range(0, 1));
            mtlo_i = 1'($urandom_range(0, 1));
         end
         div0_i  = ($urandom_range(0, 7) == 0);
         wdata_i = $urandom;
         rd_hi_i = 1'($urandom_range(0, 1));
         if (m_busy == 0) aluout_i = {$urandom, $urandom};
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
